// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam int MAXN = 64;

   function automatic logic [MAXN-1:0] to_onehot(
      input int unsigned idx
   );
      to_onehot = '0;
      to_onehot[idx[5:0]] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Request/data/grant bundle between requesters and the arbiter.
interface rr_mux_arbiter_if #(
   parameter int N = 8,
   parameter int M = $clog2(N)
);

   logic [N-1:0] req;
   logic [N-1:0] inp;
   logic [N-1:0] grant;
   logic [M-1:0] select;
   logic         out;
   logic         out_valid;

   modport master (
      output req, inp,
      input  grant, select, out, out_valid
   );

   modport slave (
      input  req, inp,
      output grant, select, out, out_valid
   );

endinterface

// File: rtl/mux_n1.sv
// Parameterized N-to-1 single-bit multiplexer.
module mux_n1 #(
   parameter int N = 8,
   parameter int M = $clog2(N)
) (
   input  logic [N-1:0] d,
   input  logic [M-1:0] sel,
   output logic         y
);

   assign y = d[sel];

endmodule

// File: rtl/rr_mux_arbiter_pick.sv
// Masked priority scan: first set request at or after ptr, mod N.
module rr_pick #(
   parameter int N = 8,
   parameter int M = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [M-1:0] ptr,
   output logic [M-1:0] win,
   output logic         any
);

   logic [M-1:0] idx;

   always_comb begin
      win = '0;
      any = 1'b0;
      idx = '0;
      for (int k = 0; k < N; k++) begin
         idx = ptr + M'(k);
         if (!any && req[idx]) begin
            any = 1'b1;
            win = idx;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin owner selection with hold limit driving a shared N:1 mux.
module rr_mux_arbiter
   import rr_mux_arbiter_pkg::*;
#(
   parameter int N        = 8,
   parameter int M        = $clog2(N),
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_mux_arbiter_if.slave bus
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

   state_t        state;
   logic [M-1:0]  ptr;
   logic [M-1:0]  win;
   logic [M-1:0]  sel_q;
   logic [HW-1:0] hold_cnt;
   logic [N-1:0]  grant_q;
   logic          out_q;
   logic          vld_q;
   logic          any;
   logic          mux_y;
   logic          own;
   logic          others;
   logic          hold_exp;
   logic          take;

   rr_pick #(.N(N), .M(M)) u_pick (
      .req (bus.req),
      .ptr (ptr),
      .win (win),
      .any (any)
   );

   mux_n1 #(.N(N), .M(M)) u_mux (
      .d   (bus.inp),
      .sel (sel_q),
      .y   (mux_y)
   );

   // grant_q is zero in IDLE, so own=0 and others=any there
   assign own      = |(bus.req & grant_q);
   assign others   = |(bus.req & ~grant_q);
   assign hold_exp = (hold_cnt == LAST);
   assign take     = any && (!own || (hold_exp && others));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         grant_q  <= '0;
         sel_q    <= '0;
         out_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         vld_q <= |grant_q;
         if (|grant_q) out_q <= mux_y;
         unique case (state)
            IDLE: begin
               if (take) begin
                  state    <= GRANT;
                  grant_q  <= N'(to_onehot(32'(win)));
                  sel_q    <= win;
                  ptr      <= win + M'(1);
                  hold_cnt <= '0;
               end
            end
            GRANT: begin
               if (!any) begin
                  state   <= IDLE;
                  grant_q <= '0;
               end else if (take) begin
                  grant_q  <= N'(to_onehot(32'(win)));
                  sel_q    <= win;
                  ptr      <= win + M'(1);
                  hold_cnt <= '0;
               end else if (!hold_exp) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.select    = sel_q;
   assign bus.out       = out_q;
   assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized bench for rr_mux_arbiter against an owner/ptr/held-count model.
module tb_rr_mux_arbiter;

   localparam int N  = 8;
   localparam int M  = 3;
   localparam int MH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rr_mux_arbiter_if #(.N(N)) bus ();

   rr_mux_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errs = 0;
   int checks = 0;

   int owner;
   int ptr;
   int held;
   logic [N-1:0] eg;
   logic [M-1:0] es;
   logic eo;
   logic ev;

   task automatic mreset();
      owner = -1; ptr = 0; held = 0;
      eg = '0; es = '0; eo = 1'b0; ev = 1'b0;
   endtask

   function automatic int pick(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (p + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic grant_to(int w);
      owner = w;
      ptr   = (w + 1) % N;
      held  = 1;
   endtask

   // One clock edge: advance the model from the inputs seen at the edge.
   task automatic tick();
      logic [N-1:0] r;
      logic [N-1:0] d;
      logic [N-1:0] oth;
      int w;
      @(posedge clk);
      r = bus.req;
      d = bus.inp;
      ev = (owner >= 0);
      if (owner >= 0) eo = d[owner];
      w = pick(r, ptr);
      oth = r;
      if (owner >= 0) oth[owner] = 1'b0;
      if (owner < 0 || !r[owner]) begin
         if (w >= 0) grant_to(w);
         else owner = -1;
      end else if (held >= MH && oth != 0) begin
         grant_to(w);
      end else begin
         held++;
      end
      eg = '0;
      if (owner >= 0) begin
         eg[owner] = 1'b1;
         es = M'(owner);
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req = '0;
      mreset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req = '0;
      bus.inp = '0;
      mreset();
      #12;
      checks++;
      if ({bus.grant, bus.select, bus.out, bus.out_valid} !== '0) begin
         errs++;
         $display("FAIL reset_init: got g=%h s=%0d o=%b v=%b want all 0",
                  bus.grant, bus.select, bus.out, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bus.req = 8'hFF;
      for (int c = 0; c < 6; c++) begin
         bus.inp = N'($urandom);
         tick();
         checks++;
         if ({bus.grant, bus.select, bus.out, bus.out_valid} !==
             {eg, es, eo, ev}) begin
            errs++;
            $display("FAIL reset_run: got g=%h s=%0d o=%b v=%b want g=%h s=%0d o=%b v=%b",
                     bus.grant, bus.select, bus.out, bus.out_valid, eg, es, eo, ev);
         end
      end
      bus.inp = 8'hFF;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      mreset();
      checks++;
      if ({bus.grant, bus.select, bus.out, bus.out_valid} !== '0) begin
         errs++;
         $display("FAIL reset_async: got g=%h s=%0d o=%b v=%b want all 0",
                  bus.grant, bus.select, bus.out, bus.out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.grant !== 8'h01 || bus.select !== 3'd0) begin
         errs++;
         $display("FAIL reset_first: got g=%h s=%0d want g=01 s=0",
                  bus.grant, bus.select);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req = 8'h08;
      for (int c = 0; c < 10; c++) begin
         bus.inp = N'($urandom);
         tick();
         checks++;
         if ({bus.grant, bus.select, bus.out, bus.out_valid} !==
             {eg, es, eo, ev}) begin
            errs++;
            $display("FAIL single_model: got g=%h s=%0d o=%b v=%b want g=%h s=%0d o=%b v=%b",
                     bus.grant, bus.select, bus.out, bus.out_valid, eg, es, eo, ev);
         end
         checks++;
         if (bus.grant !== 8'h08 || bus.select !== 3'd3) begin
            errs++;
            $display("FAIL single_grant: got g=%h s=%0d want g=08 s=3",
                     bus.grant, bus.select);
         end
      end
   endtask

   task automatic test_fairness();
      logic [N-1:0] want;
      do_reset();
      bus.req = 8'hFF;
      for (int c = 1; c <= 36; c++) begin
         bus.inp = N'($urandom);
         tick();
         want = N'(1) << (((c - 1) / MH) % N);
         checks++;
         if (bus.grant !== want) begin
            errs++;
            $display("FAIL fair_order: cycle %0d got g=%h want g=%h",
                     c, bus.grant, want);
         end
         checks++;
         if ({bus.grant, bus.select, bus.out, bus.out_valid} !==
             {eg, es, eo, ev}) begin
            errs++;
            $display("FAIL fair_model: got g=%h s=%0d o=%b v=%b want g=%h s=%0d o=%b v=%b",
                     bus.grant, bus.select, bus.out, bus.out_valid, eg, es, eo, ev);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.req = 8'h80;
      bus.inp = N'($urandom);
      tick();
      bus.req = 8'h81;
      for (int i = 0; i < 8; i++) begin
         bus.inp = N'($urandom);
         tick();
         checks++;
         if ({bus.grant, bus.select, bus.out, bus.out_valid} !==
             {eg, es, eo, ev}) begin
            errs++;
            $display("FAIL wrap_model: got g=%h s=%0d o=%b v=%b want g=%h s=%0d o=%b v=%b",
                     bus.grant, bus.select, bus.out, bus.out_valid, eg, es, eo, ev);
         end
         if (i == 3) begin
            checks++;
            if (bus.grant !== 8'h01) begin
               errs++;
               $display("FAIL wrap_to0: got g=%h want g=01", bus.grant);
            end
         end
         if (i == 7) begin
            checks++;
            if (bus.grant !== 8'h80) begin
               errs++;
               $display("FAIL wrap_to7: got g=%h want g=80", bus.grant);
            end
         end
      end
   endtask

   task automatic test_early_drain();
      logic last;
      do_reset();
      bus.req = 8'h04;
      bus.inp = N'($urandom);
      tick();
      bus.req = 8'h20;
      for (int i = 0; i < 2; i++) begin
         bus.inp = N'($urandom);
         tick();
         checks++;
         if (bus.grant !== 8'h20 || bus.out_valid !== 1'b1) begin
            errs++;
            $display("FAIL early_switch: got g=%h v=%b want g=20 v=1",
                     bus.grant, bus.out_valid);
         end
         checks++;
         if ({bus.grant, bus.select, bus.out, bus.out_valid} !==
             {eg, es, eo, ev}) begin
            errs++;
            $display("FAIL early_model: got g=%h s=%0d o=%b v=%b want g=%h s=%0d o=%b v=%b",
                     bus.grant, bus.select, bus.out, bus.out_valid, eg, es, eo, ev);
         end
      end
      bus.req = '0;
      bus.inp = N'($urandom);
      tick();
      checks++;
      if (bus.grant !== '0 || bus.out_valid !== 1'b1 || bus.select !== 3'd5) begin
         errs++;
         $display("FAIL drain_edge: got g=%h s=%0d v=%b want g=00 s=5 v=1",
                  bus.grant, bus.select, bus.out_valid);
      end
      last = bus.out;
      for (int i = 0; i < 3; i++) begin
         bus.inp = N'($urandom);
         tick();
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out !== last || bus.select !== 3'd5) begin
            errs++;
            $display("FAIL drain_hold: got o=%b v=%b s=%0d want o=%b v=0 s=5",
                     bus.out, bus.out_valid, bus.select, last);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      bus.req = '0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0)
            bus.req = N'($urandom & $urandom);
         bus.inp = N'($urandom);
         tick();
         checks++;
         if ({bus.grant, bus.select, bus.out, bus.out_valid} !==
             {eg, es, eo, ev}) begin
            errs++;
            $display("FAIL rand_model: c=%0d got g=%h s=%0d o=%b v=%b want g=%h s=%0d o=%b v=%b",
                     c, bus.grant, bus.select, bus.out, bus.out_valid, eg, es, eo, ev);
         end
      end
   endtask

   initial begin
      bus.req = '0;
      bus.inp = '0;
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_early_drain();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
